// File: rtl/elastic_pkg.sv
// Shared sizing helpers for the elastic FIFO and its pointer counters.
// Both the FIFO and the counters derive their widths here so the two can never disagree.
package elastic_pkg;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/elastic_fifo_wrap_counter.sv
// Modulo counter running 0..max_p and wrapping back to 0; used for FIFO read/write pointers.
// The wrap is an explicit compare, so non-power-of-two ranges behave correctly.
module wrap_counter
    import elastic_pkg::*;
#(
    parameter int max_p   = 3,
    parameter int width_p = ptr_width(max_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] MaxC = width_p'(max_p);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == MaxC) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/elastic_fifo.sv
// Multi-entry ready/valid elastic buffer with occupancy count, almost-full flag and flush.
// Flop-array storage; data_o is the head entry with no write-to-read bypass.
module elastic_fifo
    import elastic_pkg::*;
#(
    parameter int width_p          = 8,
    parameter int depth_p          = 4,
    parameter int almost_full_p    = 3,
    parameter int datapath_reset_p = 0,
    parameter int datapath_gate_p  = 1
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [width_p-1:0]                data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic                              valid_o,
    output logic [width_p-1:0]                data_o,
    input  logic                              ready_i,
    input  logic                              flush_i,
    output logic [count_width(depth_p)-1:0]   count_o,
    output logic                              almost_full_o
);

    localparam int CntW = count_width(depth_p);
    localparam int PtrW = ptr_width(depth_p);

    localparam logic [CntW-1:0] DepthC = CntW'(depth_p);
    localparam logic [CntW-1:0] AfC    = CntW'(almost_full_p);

    if (depth_p < 2) begin : g_bad_depth
        $error("elastic_fifo: depth_p must be at least 2");
    end
    if (almost_full_p < 1 || almost_full_p > depth_p) begin : g_bad_af
        $error("elastic_fifo: almost_full_p must lie in 1..depth_p");
    end
    if (width_p < 1) begin : g_bad_width
        $error("elastic_fifo: width_p must be at least 1");
    end

    logic [CntW-1:0]    count_q;
    logic [CntW-1:0]    count_d;
    logic [PtrW-1:0]    wr_ptr;
    logic [PtrW-1:0]    rd_ptr;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               mem_we;
    logic [width_p-1:0] mem_q [depth_p];

    assign full  = (count_q == DepthC);
    assign empty = (count_q == '0);

    // At full, a same-cycle pop frees the slot, so ready_i reaches ready_o combinationally.
    assign ready_o = ~flush_i & (~full | ready_i);
    assign valid_o = ~flush_i & ~empty;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o       = count_q;
    assign almost_full_o = (count_q >= AfC);

    wrap_counter #(
        .max_p   (depth_p - 1),
        .width_p (PtrW)
    ) u_wr_ptr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (flush_i),
        .en_i     (push),
        .count_o  (wr_ptr)
    );

    wrap_counter #(
        .max_p   (depth_p - 1),
        .width_p (PtrW)
    ) u_rd_ptr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (flush_i),
        .en_i     (pop),
        .count_o  (rd_ptr)
    );

    // Ungated writes are safe: wr_ptr only moves on push, so a stray write lands in a free slot.
    assign mem_we = (datapath_gate_p != 0) ? push : ready_o;

    if (datapath_reset_p != 0) begin : g_mem_rst
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                for (int i = 0; i < depth_p; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (mem_we) begin
                mem_q[wr_ptr] <= data_i;
            end
        end
    end else begin : g_mem_norst
        always_ff @(posedge clk_i) begin
            if (mem_we) begin
                mem_q[wr_ptr] <= data_i;
            end
        end
    end

    assign data_o = mem_q[rd_ptr];

`ifndef SYNTHESIS
    a_count_range : assert property (@(posedge clk_i) disable iff (!reset_ni)
        count_q <= DepthC);
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(pop && empty));
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(push && !pop && full));
`endif

endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo: two instances (depth 4 reset storage/gated, depth 3 unreset/ungated)
// share one stimulus stream and are compared every cycle against queue-based models.
module tb_elastic_fifo;

    logic       clk_i;
    logic       reset_ni;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_i;
    logic       flush_i;

    logic       rdy4, vld4, af4;
    logic [7:0] dat4;
    logic [2:0] cnt4;
    logic       rdy3, vld3, af3;
    logic [7:0] dat3;
    logic [1:0] cnt3;

    int checks;
    int errors;

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    bit         p4, o4, p3, o3;

    elastic_fifo #(
        .width_p(8), .depth_p(4), .almost_full_p(3),
        .datapath_reset_p(1), .datapath_gate_p(1)
    ) u_dut4 (
        .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
        .ready_o(rdy4), .valid_o(vld4), .data_o(dat4), .ready_i(ready_i),
        .flush_i(flush_i), .count_o(cnt4), .almost_full_o(af4)
    );

    elastic_fifo #(
        .width_p(8), .depth_p(3), .almost_full_p(2),
        .datapath_reset_p(0), .datapath_gate_p(0)
    ) u_dut3 (
        .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
        .ready_o(rdy3), .valid_o(vld3), .data_o(dat3), .ready_i(ready_i),
        .flush_i(flush_i), .count_o(cnt3), .almost_full_o(af3)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: a FIFO is a queue; accept when not flushing and (not full or consumer ready).
    always @(posedge clk_i) begin
        if (reset_ni) begin
            o4 = !flush_i && (q4.size() != 0) && ready_i;
            p4 = valid_i && !flush_i && ((q4.size() != 4) || ready_i);
            o3 = !flush_i && (q3.size() != 0) && ready_i;
            p3 = valid_i && !flush_i && ((q3.size() != 3) || ready_i);
            if (flush_i) begin
                q4.delete();
                q3.delete();
            end else begin
                if (o4) void'(q4.pop_front());
                if (p4) q4.push_back(data_i);
                if (o3) void'(q3.pop_front());
                if (p3) q3.push_back(data_i);
            end
        end
    end

    always @(negedge reset_ni) begin
        q4.delete();
        q3.delete();
    end

    always @(negedge clk_i) begin
        chk("ready4", {31'd0, rdy4}, {31'd0, !flush_i && ((q4.size() != 4) || ready_i)});
        chk("valid4", {31'd0, vld4}, {31'd0, !flush_i && (q4.size() != 0)});
        chk("count4", {29'd0, cnt4}, q4.size());
        chk("afull4", {31'd0, af4}, {31'd0, q4.size() >= 3});
        if (!flush_i && q4.size() != 0) chk("data4", {24'd0, dat4}, {24'd0, q4[0]});
        chk("ready3", {31'd0, rdy3}, {31'd0, !flush_i && ((q3.size() != 3) || ready_i)});
        chk("valid3", {31'd0, vld3}, {31'd0, !flush_i && (q3.size() != 0)});
        chk("count3", {30'd0, cnt3}, q3.size());
        chk("afull3", {31'd0, af3}, {31'd0, q3.size() >= 2});
        if (!flush_i && q3.size() != 0) chk("data3", {24'd0, dat3}, {24'd0, q3[0]});
    end

    initial begin
        checks   = 0;
        errors   = 0;
        reset_ni = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        flush_i  = 1'b0;
        data_i   = 8'h00;

        repeat (2) cyc();
        chk("rst_valid", {31'd0, vld4}, 32'd0);
        chk("rst_ready", {31'd0, rdy4}, 32'd1);
        chk("rst_count", {29'd0, cnt4}, 32'd0);
        chk("rst_afull", {31'd0, af4}, 32'd0);
        chk("rst_data", {24'd0, dat4}, 32'd0);
        reset_ni = 1'b1;

        // Fill with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = 8'hA1 + 8'(i);
            ready_i = 1'b0;
            cyc();
            #1;
            chk("fill_count", {29'd0, cnt4}, i + 1);
            chk("fill_afull", {31'd0, af4}, (i + 1 >= 3) ? 32'd1 : 32'd0);
        end
        chk("full_ready", {31'd0, rdy4}, 32'd0);
        chk("full_head", {24'd0, dat4}, 32'hA1);

        // Full pass-through: consumer ready opens the input the same cycle.
        data_i  = 8'hA5;
        ready_i = 1'b1;
        #1;
        chk("pass_ready", {31'd0, rdy4}, 32'd1);
        chk("pass_head", {24'd0, dat4}, 32'hA1);
        cyc();
        valid_i = 1'b0;
        #1;
        chk("pass_count", {29'd0, cnt4}, 32'd4);
        chk("pass_next", {24'd0, dat4}, 32'hA2);

        for (int i = 0; i < 4; i++) begin
            chk("drain_data", {24'd0, dat4}, 32'hA2 + i);
            chk("drain_valid", {31'd0, vld4}, 32'd1);
            cyc();
            #1;
        end
        chk("drained_valid", {31'd0, vld4}, 32'd0);
        chk("drained_count", {29'd0, cnt4}, 32'd0);

        // Flush with a handshake attempted on both sides.
        valid_i = 1'b1;
        ready_i = 1'b0;
        data_i  = 8'h11;
        cyc();
        data_i = 8'h22;
        cyc();
        data_i  = 8'h99;
        ready_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("flush_ready", {31'd0, rdy4}, 32'd0);
        chk("flush_valid", {31'd0, vld4}, 32'd0);
        cyc();
        flush_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'h55;
        #1;
        chk("flush_count", {29'd0, cnt4}, 32'd0);
        cyc();
        valid_i = 1'b0;
        #1;
        chk("post_flush_data", {24'd0, dat4}, 32'h55);
        chk("post_flush_count", {29'd0, cnt4}, 32'd1);
        ready_i = 1'b1;
        cyc();

        // Random traffic in phases of differing consumer throughput.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 120; n++) begin
                valid_i = ($urandom_range(0, 3) != 0);
                ready_i = ($urandom_range(0, 3) < ph + 1);
                flush_i = ($urandom_range(0, 60) == 0);
                data_i  = 8'($urandom);
                cyc();
            end
        end

        // Asynchronous reset between edges with three words held.
        valid_i = 1'b0;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_i = 8'hC0 + 8'(i);
            cyc();
        end
        valid_i = 1'b0;
        #1;
        chk("pre_rst_count", {29'd0, cnt4}, 32'd3);
        #1;
        reset_ni = 1'b0;
        #1;
        chk("async_count", {29'd0, cnt4}, 32'd0);
        chk("async_valid", {31'd0, vld4}, 32'd0);
        chk("async_afull", {31'd0, af4}, 32'd0);
        chk("async_count3", {30'd0, cnt3}, 32'd0);
        cyc();
        reset_ni = 1'b1;
        valid_i  = 1'b1;
        data_i   = 8'h3C;
        cyc();
        valid_i = 1'b0;
        #1;
        chk("post_rst_data", {24'd0, dat4}, 32'h3C);
        chk("post_rst_count", {29'd0, cnt4}, 32'd1);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
